// File: rtl/ex_muldiv_stage_if.sv
// Issue, forwarding and result bus between EX-stage control and the multiply/divide unit.
interface ex_muldiv_stage_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] iDatabusA;
  logic [WIDTH-1:0] iDatabusB;
  logic [WIDTH-1:0] iEXMEM_forward_data;
  logic [WIDTH-1:0] iMEMWB_forward_data;
  logic [1:0]       iForwardA;
  logic [1:0]       iForwardB;
  logic             iStart;
  logic [3:0]       iOp;
  logic             iFlush;
  logic             oStall;
  logic             oBusy;
  logic [WIDTH-1:0] oResult;
  logic [WIDTH-1:0] oHi;
  logic [WIDTH-1:0] oLo;
  logic             oDivZero;

  modport master (
    output iDatabusA, iDatabusB, iEXMEM_forward_data, iMEMWB_forward_data,
           iForwardA, iForwardB, iStart, iOp, iFlush,
    input  oStall, oBusy, oResult, oHi, oLo, oDivZero
  );

  modport slave (
    input  iDatabusA, iDatabusB, iEXMEM_forward_data, iMEMWB_forward_data,
           iForwardA, iForwardB, iStart, iOp, iFlush,
    output oStall, oBusy, oResult, oHi, oLo, oDivZero
  );
endinterface

// File: rtl/ex_muldiv_stage.sv
// EX-stage iterative multiply/divide unit with HI/LO registers and forwarded operands.
// Define MADD_EN to add MADD/MADDU accumulate into {HI,LO}.
module ex_muldiv_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input logic             clk,
  input logic             reset,
  ex_muldiv_stage_if.slave bus
);
  localparam int unsigned PW = 2 * WIDTH;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
`endif

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [PW-1:0]    prod;
  logic [WIDTH-1:0] hi, lo, opA, opB;
  logic             isDiv, isSigned, negA, negB, divZero, divZeroPulse;
`ifdef MADD_EN
  logic             isMadd;
`endif

  logic [WIDTH-1:0] fa, fb, magA, magB;
  logic             decMul, decDiv, decSigned, decMadd, accept;

  // Bypass selection, resolved every cycle.
  always_comb begin
    case (bus.iForwardA)
      2'b10:   fa = bus.iEXMEM_forward_data;
      2'b01:   fa = bus.iMEMWB_forward_data;
      default: fa = bus.iDatabusA;
    endcase
    case (bus.iForwardB)
      2'b10:   fb = bus.iEXMEM_forward_data;
      2'b01:   fb = bus.iMEMWB_forward_data;
      default: fb = bus.iDatabusB;
    endcase
  end

  always_comb begin
    decMul    = 1'b0;
    decDiv    = 1'b0;
    decSigned = 1'b0;
    decMadd   = 1'b0;
    case (bus.iOp)
      OP_MULT:  begin decMul = 1'b1; decSigned = 1'b1; end
      OP_MULTU: decMul = 1'b1;
      OP_DIV:   begin decDiv = 1'b1; decSigned = 1'b1; end
      OP_DIVU:  decDiv = 1'b1;
`ifdef MADD_EN
      OP_MADD:  begin decMul = 1'b1; decSigned = 1'b1; decMadd = 1'b1; end
      OP_MADDU: begin decMul = 1'b1; decMadd = 1'b1; end
`endif
      default:  ;
    endcase
  end

  assign accept = bus.iStart && (state == IDLE) && !bus.iFlush;
  assign magA   = (decSigned && fa[WIDTH-1]) ? WIDTH'(-fa) : fa;
  assign magB   = (decSigned && fb[WIDTH-1]) ? WIDTH'(-fb) : fb;

  // One shift-add step (multiplier in prod low half) and one restoring-divide step
  // (remainder in prod high half, dividend shifting out of the low half).
  logic [WIDTH:0]   mulSum, divShift, divDiff;
  logic [PW-1:0]    mulRes;
  logic [WIDTH-1:0] quo, rem;
  assign mulSum   = {1'b0, prod[PW-1:WIDTH]} + (prod[0] ? {1'b0, opA} : {(WIDTH+1){1'b0}});
  assign divShift = {prod[PW-1:WIDTH], prod[WIDTH-1]};
  assign divDiff  = divShift - {1'b0, opB};
  assign mulRes   = (isSigned && (negA ^ negB)) ? PW'(-prod) : prod;
  assign quo      = (isSigned && (negA ^ negB)) ? WIDTH'(-prod[WIDTH-1:0]) : prod[WIDTH-1:0];
  assign rem      = (isSigned && negA) ? WIDTH'(-prod[PW-1:WIDTH]) : prod[PW-1:WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      prod         <= '0;
      hi           <= '0;
      lo           <= '0;
      opA          <= '0;
      opB          <= '0;
      isDiv        <= 1'b0;
      isSigned     <= 1'b0;
      negA         <= 1'b0;
      negB         <= 1'b0;
      divZero      <= 1'b0;
      divZeroPulse <= 1'b0;
`ifdef MADD_EN
      isMadd       <= 1'b0;
`endif
    end else begin
      divZeroPulse <= 1'b0;
      if (bus.iFlush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (accept) begin
            if (bus.iOp == OP_MTHI) hi <= fa;
            if (bus.iOp == OP_MTLO) lo <= fa;
            if (decMul || decDiv) begin
              opA      <= magA;
              opB      <= magB;
              isDiv    <= decDiv;
              isSigned <= decSigned;
              negA     <= decSigned && fa[WIDTH-1];
              negB     <= decSigned && fb[WIDTH-1];
`ifdef MADD_EN
              isMadd   <= decMadd;
`endif
              cnt      <= CNT_W'(WIDTH - 1);
              if (decDiv && (fb == '0)) begin
                // Zero divisor: stash the architectural result, skip iteration.
                prod         <= {fa, {WIDTH{1'b1}}};
                divZero      <= 1'b1;
                divZeroPulse <= 1'b1;
                state        <= FIX;
              end else begin
                prod    <= decMul ? {{WIDTH{1'b0}}, magB} : {{WIDTH{1'b0}}, magA};
                divZero <= 1'b0;
                state   <= decMul ? MUL : DIV;
              end
            end
          end
          MUL: begin
            prod <= {mulSum, prod[WIDTH-1:1]};
            cnt  <= cnt - CNT_W'(1);
            if (cnt == '0) state <= FIX;
          end
          DIV: begin
            prod <= divDiff[WIDTH] ? {divShift[WIDTH-1:0], prod[WIDTH-2:0], 1'b0}
                                   : {divDiff[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
            cnt  <= cnt - CNT_W'(1);
            if (cnt == '0) state <= FIX;
          end
          FIX: begin
            state <= IDLE;
            if (divZero) begin
              hi <= prod[PW-1:WIDTH];
              lo <= prod[WIDTH-1:0];
            end else if (isDiv) begin
              hi <= rem;
              lo <= quo;
            end
`ifdef MADD_EN
            else if (isMadd) {hi, lo} <= {hi, lo} + mulRes;
`endif
            else {hi, lo} <= mulRes;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.oStall   = bus.iStart && (state != IDLE);
  assign bus.oBusy    = (state != IDLE);
  assign bus.oHi      = hi;
  assign bus.oLo      = lo;
  assign bus.oDivZero = divZeroPulse;

  // Move-from reads are only driven in the cycle the op is accepted.
  always_comb begin
    bus.oResult = '0;
    if (accept && (bus.iOp == OP_MFHI)) bus.oResult = hi;
    if (accept && (bus.iOp == OP_MFLO)) bus.oResult = lo;
  end

  logic unusedDecMadd;
  assign unusedDecMadd = decMadd;
endmodule

// File: tb/tb_ex_muldiv_stage.sv
// Scoreboard bench for ex_muldiv_stage: stimulus queues expected HI/LO or read results,
// a negedge monitor pops and compares whenever an op completes or a move-from is accepted.
module tb_ex_muldiv_stage;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ex_muldiv_stage_if #(.WIDTH(W)) bus ();
  ex_muldiv_stage #(.WIDTH(W), .CNT_W(6)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    bit         isRes;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    string      name;
  } exp_t;

  exp_t expQ[$];
  int   nCompared = 0;
  int   nMismatch = 0;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    nCompared++;
    if (got !== want) begin
      nMismatch++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic timeoutFail(input string name);
    nCompared++;
    nMismatch++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic pushHiLo(input string name, input logic [W-1:0] hi, input logic [W-1:0] lo);
    exp_t e;
    e.isRes = 1'b0; e.hi = hi; e.lo = lo; e.name = name;
    expQ.push_back(e);
  endtask

  task automatic pushRes(input string name, input logic [W-1:0] v);
    exp_t e;
    e.isRes = 1'b1; e.hi = '0; e.lo = v; e.name = name;
    expQ.push_back(e);
  endtask

  task automatic popCheck(input bit isRes, input logic [W-1:0] hi, input logic [W-1:0] lo);
    exp_t e;
    if (expQ.size() == 0) begin
      nCompared++;
      nMismatch++;
      $display("FAIL unexpected_output: got hi=%h lo=%h want nothing", hi, lo);
      return;
    end
    e = expQ.pop_front();
    check({e.name, "_kind"}, W'(isRes), W'(e.isRes));
    if (e.isRes) begin
      check({e.name, "_result"}, lo, e.lo);
    end else begin
      check({e.name, "_hi"}, hi, e.hi);
      check({e.name, "_lo"}, lo, e.lo);
    end
  endtask

  // Monitor: completion (busy falling) and move-from accept cycles.
  initial begin : monitor
    logic prevBusy;
    prevBusy = 1'b0;
    forever begin
      @(negedge clk);
      if (prevBusy && !bus.oBusy) popCheck(1'b0, bus.oHi, bus.oLo);
      if (bus.iStart && !bus.oStall && !bus.iFlush && !reset &&
          (bus.iOp == 4'd5 || bus.iOp == 4'd6))
        popCheck(1'b1, '0, bus.oResult);
      prevBusy = bus.oBusy;
    end
  end

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int stalls);
    int n;
    n = 0;
    bus.iOp = op; bus.iDatabusA = a; bus.iDatabusB = b; bus.iStart = 1'b1;
    forever begin
      @(negedge clk);
      if (!bus.oStall) break;
      n++;
      if (n > 200) begin timeoutFail("issue_stall"); break; end
    end
    @(posedge clk); #1;
    bus.iStart = 1'b0; bus.iOp = 4'd0;
    stalls = n;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (bus.oBusy) begin
      @(negedge clk);
      n++;
      if (n > 200) begin timeoutFail("wait_idle"); break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic countBusy(output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (!bus.oBusy) break;
      n++;
      if (n > 200) begin timeoutFail("count_busy"); break; end
    end
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int s;
    int nb;
    reset = 1'b1;
    bus.iStart = 1'b0; bus.iOp = 4'd0; bus.iFlush = 1'b0;
    bus.iForwardA = 2'b00; bus.iForwardB = 2'b00;
    bus.iDatabusA = '0; bus.iDatabusB = '0;
    bus.iEXMEM_forward_data = '0; bus.iMEMWB_forward_data = '0;
    #12;
    check("reset_hi", bus.oHi, '0);
    check("reset_lo", bus.oLo, '0);
    check("reset_busy", W'(bus.oBusy), '0);
    check("reset_divzero", W'(bus.oDivZero), '0);
    check("reset_stall", W'(bus.oStall), '0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Signed multiply, busy length
    pushHiLo("mult_neg1x2", 32'hFFFFFFFF, 32'hFFFFFFFE);
    issue(4'd1, 32'hFFFFFFFF, 32'h00000002, s);
    countBusy(nb);
    check("mult_busy_cycles", W'(nb), 32'd33);

    pushHiLo("multu_ffffffffx2", 32'h00000001, 32'hFFFFFFFE);
    issue(4'd2, 32'hFFFFFFFF, 32'h00000002, s);
    waitIdle();

    // Signed divide with operand A taken from the EX/MEM bypass
    bus.iForwardA = 2'b10;
    bus.iEXMEM_forward_data = 32'hFFFFFFF9;
    bus.iMEMWB_forward_data = 32'h11111111;
    pushHiLo("div_m7_by_2_fwd", 32'hFFFFFFFF, 32'hFFFFFFFD);
    issue(4'd3, 32'h00000000, 32'h00000002, s);
    bus.iForwardA = 2'b00;
    waitIdle();

    // Divide by zero
    pushHiLo("divu_by_zero", 32'h12345678, 32'hFFFFFFFF);
    issue(4'd4, 32'h12345678, 32'h00000000, s);
    @(negedge clk);
    check("divzero_pulse", W'(bus.oDivZero), 32'd1);
    check("divzero_busy", W'(bus.oBusy), 32'd1);
    @(negedge clk);
    check("divzero_pulse_end", W'(bus.oDivZero), 32'd0);
    check("divzero_busy_end", W'(bus.oBusy), 32'd0);
    @(posedge clk); #1;

    // Move-from issued right behind a multiply stalls until completion
    pushHiLo("mult_3x5", 32'h00000000, 32'h0000000F);
    issue(4'd1, 32'd3, 32'd5, s);
    pushRes("mflo_after_mult", 32'h0000000F);
    issue(4'd6, '0, '0, s);
    check("mflo_stall_cycles", W'(s), 32'd33);
    pushRes("mfhi_after_mult", 32'h00000000);
    issue(4'd5, '0, '0, s);

    // Move-to then move-from
    issue(4'd7, 32'hDEADBEEF, '0, s);
    issue(4'd8, 32'h0BADF00D, '0, s);
    pushRes("mfhi_after_mthi", 32'hDEADBEEF);
    issue(4'd5, '0, '0, s);
    pushRes("mflo_after_mtlo", 32'h0BADF00D);
    issue(4'd6, '0, '0, s);
    @(negedge clk);
    check("result_zero_when_idle", bus.oResult, '0);
    @(posedge clk); #1;

    // Signed overflow wraps
    pushHiLo("div_min_by_m1", 32'h00000000, 32'h80000000);
    issue(4'd3, 32'h80000000, 32'hFFFFFFFF, s);
    waitIdle();

    // Signed divide with operand B from the MEM/WB bypass
    bus.iForwardB = 2'b01;
    bus.iMEMWB_forward_data = 32'hFFFFFFFE;
    bus.iEXMEM_forward_data = 32'h22222222;
    pushHiLo("div_7_by_m2_fwd", 32'h00000001, 32'hFFFFFFFD);
    issue(4'd3, 32'd7, 32'd5, s);
    bus.iForwardB = 2'b00;
    waitIdle();

    pushHiLo("divu_100_by_7", 32'h00000002, 32'h0000000E);
    issue(4'd4, 32'd100, 32'd7, s);
    waitIdle();

    // Flush mid-divide leaves HI/LO untouched
    pushHiLo("flush_mid_div", 32'h00000002, 32'h0000000E);
    issue(4'd3, 32'd1000, 32'd3, s);
    repeat (5) @(posedge clk);
    #1 bus.iFlush = 1'b1;
    @(posedge clk); #1;
    bus.iFlush = 1'b0;
    waitIdle();

    // Flush and start together in IDLE: op dropped
    bus.iFlush = 1'b1; bus.iStart = 1'b1; bus.iOp = 4'd7; bus.iDatabusA = 32'h00000055;
    @(posedge clk); #1;
    bus.iFlush = 1'b0; bus.iStart = 1'b0; bus.iOp = 4'd0;
    pushRes("mfhi_after_flush_start", 32'h00000002);
    issue(4'd5, '0, '0, s);

`ifdef MADD_EN
    pushHiLo("madd_m1x3", 32'h00000002, 32'h0000000B);
    issue(4'd9, 32'hFFFFFFFF, 32'd3, s);
    waitIdle();
    pushHiLo("maddu_ffffffffx2", 32'h00000004, 32'h00000009);
    issue(4'd10, 32'hFFFFFFFF, 32'd2, s);
    waitIdle();
`else
    issue(4'd9, 32'd3, 32'd5, s);
    @(negedge clk);
    check("nop9_busy", W'(bus.oBusy), '0);
    check("nop9_hi", bus.oHi, 32'h00000002);
    check("nop9_lo", bus.oLo, 32'h0000000E);
    @(posedge clk); #1;
`endif

    // Async reset partway through a multiply
    pushHiLo("reset_mid_mult", 32'h00000000, 32'h00000000);
    issue(4'd1, 32'd3, 32'd5, s);
    repeat (9) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("rst_mid_busy", W'(bus.oBusy), '0);
    check("rst_mid_hi", bus.oHi, '0);
    check("rst_mid_lo", bus.oLo, '0);
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;

    begin
      int n;
      n = 0;
      while (expQ.size() != 0 && n < 50) begin @(posedge clk); n++; end
    end
    check("scoreboard_drained", W'(expQ.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end
endmodule
